// File: rtl/sys_cntrl_burst_pkg.sv
// Shared command codes, FSM state encoding and default error byte for the
// burst-capable system controller.
package sys_cntrl_pkg;

  localparam logic [7:0] CMD_WR       = 8'hAA;
  localparam logic [7:0] CMD_RD       = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
  localparam logic [7:0] CMD_BURST    = 8'hEE;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CNT,
    GET_A,
    GET_B,
    GET_FUN,
    WR,
    RD_REQ,
    RD_WAIT,
    ALU_RUN,
    TX_SEND
  } state_t;

endpackage

// File: rtl/sys_cntrl_burst_if.sv
// Bundle of RX, register-file, ALU and TX FIFO signals seen by the controller.
// Strobes (RX_d_valid, RdData_valid, OUT_VALID, WrEN, RdEN, TX_d_valid) are
// single-cycle qualifiers; FIFO_full is a level that stalls TX_d_valid.
interface sys_cntrl_burst_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RES_BYTES  = 2,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]           RX_p_data;
  logic                            RX_d_valid;
  logic [DATA_WIDTH-1:0]           Rd_data;
  logic                            RdData_valid;
  logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT;
  logic                            OUT_VALID;
  logic                            FIFO_full;
  logic                            ALU_EN;
  logic [FUN_WIDTH-1:0]            ALU_FUN;
  logic                            CLK_EN;
  logic [ADDR_WIDTH-1:0]           Address;
  logic                            WrEN;
  logic                            RdEN;
  logic [DATA_WIDTH-1:0]           WrData;
  logic [DATA_WIDTH-1:0]           TX_p_data;
  logic                            TX_d_valid;
  logic                            err_pulse;
  logic                            timeout_pulse;
  logic                            clk_div_en;

  modport master (
    input  RX_p_data, RX_d_valid, Rd_data, RdData_valid, ALU_OUT, OUT_VALID, FIFO_full,
    output ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
           TX_p_data, TX_d_valid, err_pulse, timeout_pulse, clk_div_en
  );

  modport slave (
    output RX_p_data, RX_d_valid, Rd_data, RdData_valid, ALU_OUT, OUT_VALID, FIFO_full,
    input  ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData,
           TX_p_data, TX_d_valid, err_pulse, timeout_pulse, clk_div_en
  );
endinterface

// File: rtl/sys_cntrl_burst_frame_timer.sv
// Clearable wait counter: tc pulses once when TIMEOUT_CYCLES cycles pass
// without a clear, then the count saturates so it cannot fire again.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != TOP) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST) && !clr;
endmodule

// File: rtl/sys_cntrl_burst.sv
// Byte-framed command controller: register write/read/burst-read, ALU ops with
// multi-byte results, wait timeouts with error bytes and stall-safe TX.
module sys_cntrl_burst
  import sys_cntrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int RES_BYTES      = 2,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(ERR_BYTE_DEF)
) (
  input  logic              CLK,
  input  logic              RST,
  sys_cntrl_burst_if.master bus,
  output state_t            state_dbg
);
  localparam int BUF_W = RES_BYTES * DATA_WIDTH;
  localparam int CNT_W = $clog2(RES_BYTES + 1);

  state_t                  state;
  logic [7:0]              cmd;
  logic [BUF_W-1:0]        tx_buf;
  logic [CNT_W-1:0]        tx_left;
  logic [DATA_WIDTH-1:0]   burst_left;
  logic                    tmr_clr;
  logic                    tmr_tc;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [FUN_WIDTH-1:0]    alu_fun;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    wr_en, rd_en, alu_en, clk_en, tx_valid, err_p, to_p;
  logic [7:0]              rx_byte;

  assign rx_byte = bus.RX_p_data[7:0];

  // tmr_clr is raised on every state change; every accepted strobe changes state.
  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk (CLK),
    .rst (RST),
    .clr (tmr_clr),
    .tc  (tmr_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cmd        <= '0;
      tx_buf     <= '0;
      tx_left    <= '0;
      burst_left <= '0;
      tmr_clr    <= 1'b0;
      address    <= '0;
      wr_data    <= '0;
      alu_fun    <= '0;
      tx_data    <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      alu_en     <= 1'b0;
      clk_en     <= 1'b0;
      tx_valid   <= 1'b0;
      err_p      <= 1'b0;
      to_p       <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      tx_valid <= 1'b0;
      err_p    <= 1'b0;
      to_p     <= 1'b0;
      tmr_clr  <= 1'b0;
      unique case (state)
        IDLE: if (bus.RX_d_valid) begin
          cmd     <= rx_byte;
          tmr_clr <= 1'b1;
          case (rx_byte)
            CMD_WR, CMD_RD, CMD_BURST: state <= GET_ADDR;
            CMD_ALU_OP:                state <= GET_A;
            CMD_ALU_NOP:               state <= GET_FUN;
            default: begin
              err_p      <= 1'b1;
              tx_buf     <= BUF_W'(ERR_BYTE);
              tx_left    <= CNT_W'(1);
              burst_left <= '0;
              state      <= TX_SEND;
            end
          endcase
        end
        GET_ADDR: if (bus.RX_d_valid) begin
          address <= bus.RX_p_data[ADDR_WIDTH-1:0];
          tmr_clr <= 1'b1;
          if (cmd == CMD_WR) begin
            state <= GET_DATA;
          end else if (cmd == CMD_RD) begin
            burst_left <= DATA_WIDTH'(1);
            rd_en      <= 1'b1;
            state      <= RD_REQ;
          end else begin
            state <= GET_CNT;
          end
        end else if (tmr_tc) begin
          to_p <= 1'b1; tmr_clr <= 1'b1; state <= IDLE;
        end
        GET_DATA: if (bus.RX_d_valid) begin
          wr_data <= bus.RX_p_data;
          wr_en   <= 1'b1;
          tmr_clr <= 1'b1;
          state   <= WR;
        end else if (tmr_tc) begin
          to_p <= 1'b1; tmr_clr <= 1'b1; state <= IDLE;
        end
        GET_CNT: if (bus.RX_d_valid) begin
          tmr_clr <= 1'b1;
          if (bus.RX_p_data == '0) begin
            err_p      <= 1'b1;
            tx_buf     <= BUF_W'(ERR_BYTE);
            tx_left    <= CNT_W'(1);
            burst_left <= '0;
            state      <= TX_SEND;
          end else begin
            burst_left <= bus.RX_p_data;
            rd_en      <= 1'b1;
            state      <= RD_REQ;
          end
        end else if (tmr_tc) begin
          to_p <= 1'b1; tmr_clr <= 1'b1; state <= IDLE;
        end
        GET_A: if (bus.RX_d_valid) begin
          wr_data <= bus.RX_p_data;
          address <= '0;
          wr_en   <= 1'b1;
          tmr_clr <= 1'b1;
          state   <= GET_B;
        end else if (tmr_tc) begin
          to_p <= 1'b1; tmr_clr <= 1'b1; state <= IDLE;
        end
        GET_B: if (bus.RX_d_valid) begin
          wr_data <= bus.RX_p_data;
          address <= ADDR_WIDTH'(1);
          wr_en   <= 1'b1;
          tmr_clr <= 1'b1;
          state   <= GET_FUN;
        end else if (tmr_tc) begin
          to_p <= 1'b1; tmr_clr <= 1'b1; state <= IDLE;
        end
        GET_FUN: if (bus.RX_d_valid) begin
          alu_fun <= bus.RX_p_data[FUN_WIDTH-1:0];
          alu_en  <= 1'b1;
          clk_en  <= 1'b1;
          tmr_clr <= 1'b1;
          state   <= ALU_RUN;
        end else if (tmr_tc) begin
          to_p <= 1'b1; tmr_clr <= 1'b1; state <= IDLE;
        end
        WR: begin
          tmr_clr <= 1'b1;
          state   <= IDLE;
        end
        RD_REQ: begin
          tmr_clr <= 1'b1;
          state   <= RD_WAIT;
        end
        RD_WAIT: if (bus.RdData_valid) begin
          tx_buf  <= BUF_W'(bus.Rd_data);
          tx_left <= CNT_W'(1);
          tmr_clr <= 1'b1;
          state   <= TX_SEND;
        end else if (tmr_tc) begin
          to_p       <= 1'b1;
          tx_buf     <= BUF_W'(ERR_BYTE);
          tx_left    <= CNT_W'(1);
          burst_left <= '0;
          tmr_clr    <= 1'b1;
          state      <= TX_SEND;
        end
        ALU_RUN: if (bus.OUT_VALID || tmr_tc) begin
          alu_en     <= 1'b0;
          clk_en     <= 1'b0;
          to_p       <= !bus.OUT_VALID;
          tx_buf     <= bus.OUT_VALID ? bus.ALU_OUT : BUF_W'(ERR_BYTE);
          tx_left    <= bus.OUT_VALID ? CNT_W'(RES_BYTES) : CNT_W'(1);
          burst_left <= '0;
          tmr_clr    <= 1'b1;
          state      <= TX_SEND;
        end
        TX_SEND: begin
          // The pending byte stays on TX_p_data while the FIFO is full.
          tx_data <= tx_buf[DATA_WIDTH-1:0];
          if (!bus.FIFO_full) begin
            tx_valid <= 1'b1;
            tx_buf   <= tx_buf >> DATA_WIDTH;
            tx_left  <= tx_left - CNT_W'(1);
            if (tx_left == CNT_W'(1)) begin
              tmr_clr <= 1'b1;
              if (burst_left > DATA_WIDTH'(1)) begin
                burst_left <= burst_left - DATA_WIDTH'(1);
                address    <= address + ADDR_WIDTH'(1);
                rd_en      <= 1'b1;
                state      <= RD_REQ;
              end else begin
                burst_left <= '0;
                state      <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ALU_EN        = alu_en;
  assign bus.ALU_FUN       = alu_fun;
  assign bus.CLK_EN        = clk_en;
  assign bus.Address       = address;
  assign bus.WrEN          = wr_en;
  assign bus.RdEN          = rd_en;
  assign bus.WrData        = wr_data;
  assign bus.TX_p_data     = tx_data;
  assign bus.TX_d_valid    = tx_valid;
  assign bus.err_pulse     = err_p;
  assign bus.timeout_pulse = to_p;
  assign bus.clk_div_en    = 1'b1;
  assign state_dbg         = state;
endmodule

// File: tb/tb_sys_cntrl_burst.sv
// Directed bench for sys_cntrl_burst: expected writes, reads and TX bytes are
// queued from command semantics and checked against DUT strobes every cycle.
module tb_sys_cntrl_burst;
  import sys_cntrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RB = 2;
  localparam int FW = 4;
  localparam int TO = 1023;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;

  sys_cntrl_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RES_BYTES(RB), .FUN_WIDTH(FW)) bus ();

  sys_cntrl_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RES_BYTES(RB), .FUN_WIDTH(FW),
    .TIMEOUT_CYCLES(TO), .ERR_BYTE(8'hFF)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0]    exp_tx_q[$];
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [DW-1:0]    obs_tx[$];
  logic [AW+DW-1:0] last_wr = '0;
  int tx_total = 0, err_seen = 0, to_seen = 0, exp_err = 0, exp_to = 0;
  logic [FW-1:0]    exp_fun = '0;
  logic [RB*DW-1:0] alu_res = '0;
  logic             alu_hold = 1'b0;
  logic [DW-1:0]    rd_mem[16];
  logic             full_at_edge = 1'b0;
  logic [AW-1:0]    rd_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic m_read(input logic [AW-1:0] a);
    exp_rd_q.push_back(a);
    exp_tx_q.push_back(rd_mem[a]);
  endtask

  task automatic m_burst(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) m_read(a + AW'(i));
  endtask

  task automatic m_alu(input logic [RB*DW-1:0] res);
    for (int i = 0; i < RB; i++) exp_tx_q.push_back(res[i*DW +: DW]);
  endtask

  task automatic m_err_byte();
    exp_tx_q.push_back(8'hFF);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] b);
    @(negedge clk);
    bus.RX_p_data  = b;
    bus.RX_d_valid = 1'b1;
    @(negedge clk);
    bus.RX_d_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(exp_tx_q.size() == 0 && exp_wr_q.size() == 0 && exp_rd_q.size() == 0
                 && state_dbg == IDLE) && n < 3000);
    check({name, "_completes"}, n < 3000, 1'b1);
    cyc = n;
    repeat (3) @(negedge clk);
    #1;
  endtask

  // ---------------- responders ----------------
  always @(posedge clk) full_at_edge = bus.FIFO_full;

  initial begin : rd_resp
    bus.RdData_valid = 1'b0;
    bus.Rd_data      = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.RdEN) begin
        rd_addr = bus.Address;
        @(negedge clk);
        @(negedge clk);
        bus.Rd_data      = rd_mem[rd_addr];
        bus.RdData_valid = 1'b1;
        @(negedge clk);
        bus.RdData_valid = 1'b0;
      end
    end
  end

  initial begin : alu_resp
    int n;
    n = 0;
    bus.OUT_VALID = 1'b0;
    bus.ALU_OUT   = '0;
    forever begin
      @(negedge clk);
      if (bus.OUT_VALID) begin
        bus.OUT_VALID = 1'b0;
      end else if (!rst && bus.ALU_EN && !alu_hold) begin
        n++;
        if (n == 3) begin
          n = 0;
          check("alu_fun", bus.ALU_FUN, exp_fun);
          check("alu_clk_en", bus.CLK_EN, 1'b1);
          bus.ALU_OUT   = alu_res;
          bus.OUT_VALID = 1'b1;
        end
      end else begin
        n = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.TX_d_valid) begin
        tx_total++;
        obs_tx.push_back(bus.TX_p_data);
        check("tx_while_full", full_at_edge, 1'b0);
        check("tx_expected_pending", exp_tx_q.size() != 0, 1'b1);
        if (exp_tx_q.size() != 0) check("tx_byte", bus.TX_p_data, exp_tx_q.pop_front());
      end
      if (bus.WrEN) begin
        last_wr = {bus.Address, bus.WrData};
        check("wr_expected_pending", exp_wr_q.size() != 0, 1'b1);
        if (exp_wr_q.size() != 0) check("wr_addr_data", {bus.Address, bus.WrData}, exp_wr_q.pop_front());
      end
      if (bus.RdEN) begin
        check("rd_expected_pending", exp_rd_q.size() != 0, 1'b1);
        if (exp_rd_q.size() != 0) check("rd_addr", bus.Address, exp_rd_q.pop_front());
      end
      if (bus.err_pulse) err_seen++;
      if (bus.timeout_pulse) to_seen++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int cyc, base;
    for (int i = 0; i < 16; i++) rd_mem[i] = 8'h40 + DW'(i * 3);
    rd_mem[3] = 8'h77;
    bus.RX_p_data  = '0;
    bus.RX_d_valid = 1'b0;
    bus.FIFO_full  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;

    // Reset state
    check("rst_state", state_dbg, IDLE);
    check("rst_outs", {bus.ALU_EN, bus.CLK_EN, bus.WrEN, bus.RdEN, bus.TX_d_valid,
                       bus.err_pulse, bus.timeout_pulse}, 7'b0);
    check("rst_address", bus.Address, 4'h0);
    check("rst_wrdata", bus.WrData, 8'h00);
    check("rst_alu_fun", bus.ALU_FUN, 4'h0);
    check("rst_tx_data", bus.TX_p_data, 8'h00);
    check("clk_div_en", bus.clk_div_en, 1'b1);

    // Register write
    m_write(4'h5, 8'h5A);
    send(8'hAA); send(8'h05); send(8'h5A);
    wait_idle("write", cyc);
    check("write_lit", last_wr, {4'h5, 8'h5A});
    check("write_no_tx", tx_total, 0);

    // Register read
    m_read(4'h3);
    send(8'hBB); send(8'h03);
    wait_idle("read", cyc);
    check("read_lit", obs_tx[obs_tx.size()-1], 8'h77);

    // ALU op with operands
    exp_fun = 4'h2;
    alu_res = 16'h03A8;
    m_write(4'h0, 8'h12);
    m_write(4'h1, 8'h34);
    m_alu(alu_res);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
    wait_idle("alu", cyc);
    check("alu_lsb_lit", obs_tx[obs_tx.size()-2], 8'hA8);
    check("alu_msb_lit", obs_tx[obs_tx.size()-1], 8'h03);
    check("alu_en_off", bus.ALU_EN, 1'b0);

    // Burst read wrapping 0xF -> 0x0, FIFO stall during the second byte
    base = tx_total;
    m_burst(4'hE, 3);
    send(8'hEE); send(8'h0E); send(8'h03);
    cyc = 0;
    while (tx_total < base + 1 && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    check("burst_first_byte", tx_total, base + 1);
    bus.FIFO_full = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("burst_stall_hold", tx_total, base + 1);
    bus.FIFO_full = 1'b0;
    wait_idle("burst", cyc);
    check("burst_count", tx_total, base + 3);
    check("burst_b0_lit", obs_tx[obs_tx.size()-3], 8'h6A);
    check("burst_b1_lit", obs_tx[obs_tx.size()-2], 8'h6D);
    check("burst_b2_lit", obs_tx[obs_tx.size()-1], 8'h40);

    // Unknown command and zero-count burst
    exp_err++;
    m_err_byte();
    send(8'h42);
    wait_idle("bad_cmd", cyc);
    check("bad_cmd_lit", obs_tx[obs_tx.size()-1], 8'hFF);
    exp_err++;
    m_err_byte();
    send(8'hEE); send(8'h00); send(8'h00);
    wait_idle("zero_burst", cyc);
    check("err_count", err_seen, exp_err);

    // Inter-byte timeout: no TX, back to IDLE after about TIMEOUT_CYCLES
    base = tx_total;
    exp_to++;
    send(8'hBB);
    wait_idle("rx_timeout", cyc);
    check("rx_timeout_not_early", cyc >= TO - 3, 1'b1);
    check("rx_timeout_not_late", cyc <= TO + 6, 1'b1);
    check("rx_timeout_count", to_seen, exp_to);
    check("rx_timeout_no_tx", tx_total, base);

    // ALU response timeout: error byte, enables dropped
    alu_hold = 1'b1;
    exp_to++;
    m_err_byte();
    send(8'hDD); send(8'h05);
    wait_idle("alu_timeout", cyc);
    check("alu_timeout_count", to_seen, exp_to);
    check("alu_timeout_en", {bus.ALU_EN, bus.CLK_EN}, 2'b00);
    check("alu_timeout_lit", obs_tx[obs_tx.size()-1], 8'hFF);

    // Reset in ALU_RUN abandons the frame
    base = tx_total;
    send(8'hDD); send(8'h07);
    repeat (4) @(negedge clk);
    #1;
    check("pre_rst_alu_en", bus.ALU_EN, 1'b1);
    check("pre_rst_state", state_dbg, ALU_RUN);
    #2 rst = 1'b1;
    #1;
    check("rst_alu_en", bus.ALU_EN, 1'b0);
    check("rst_to_idle", state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;
    alu_hold = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_no_tx", tx_total, base);

    // Recovery after reset
    m_read(4'h9);
    send(8'hBB); send(8'h09);
    wait_idle("recover", cyc);
    check("recover_lit", obs_tx[obs_tx.size()-1], 8'h5B);

    check("final_err_count", err_seen, exp_err);
    check("final_tx_q_empty", exp_tx_q.size(), 0);
    check("final_wr_q_empty", exp_wr_q.size(), 0);
    check("final_rd_q_empty", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sys_cntrl_burst.md
Name: sys_cntrl_burst

Overview:
Parametrised next-generation system controller. Decodes byte-framed commands from the UART RX path, drives the register file and ALU, and returns results to the TX FIFO. Adds the following over the current controller:
- burst register read
- multi-byte ALU results
- inter-byte and response timeouts with error bytes
- lossless TX back-pressure

Parameters:
- DATA_WIDTH, 8: RX/TX byte width and register-file data width.
- ADDR_WIDTH, 4: register-file address width.
- RES_BYTES, 2: number of ALU result bytes returned. ALU_OUT width is RES_BYTES*DATA_WIDTH.
- FUN_WIDTH, 4: ALU function code width.
- TIMEOUT_CYCLES, 1023: maximum wait cycles for the next RX byte, RdData_valid or OUT_VALID.
- ERR_BYTE, 8'hFF: byte sent on an error response.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- RX_p_data  in  DATA_WIDTH  received byte.
- RX_d_valid  in  1  one-cycle strobe per received byte.
- Rd_data  in  DATA_WIDTH  register-file read data.
- RdData_valid  in  1  read data valid.
- ALU_OUT  in  RES_BYTES*DATA_WIDTH  ALU result.
- OUT_VALID  in  1  ALU result valid.
- FIFO_full  in  1  TX FIFO full.
- ALU_EN  out  1  ALU enable.
- ALU_FUN  out  FUN_WIDTH  ALU function code.
- CLK_EN  out  1  ALU clock-gate enable.
- Address  out  ADDR_WIDTH  register-file address.
- WrEN  out  1  write strobe.
- RdEN  out  1  read strobe.
- WrData  out  DATA_WIDTH  write data.
- TX_p_data  out  DATA_WIDTH  byte to TX FIFO.
- TX_d_valid  out  1  TX write strobe.
- err_pulse  out  1  one-cycle pulse on unknown command or zero burst count.
- timeout_pulse  out  1  one-cycle pulse on any timeout.
- clk_div_en  out  1  tied to 1.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-high on RST. All outputs, including ALU_FUN, Address and WrData, are registered and reset to 0; FSM resets to IDLE. RST asserted mid-frame abandons the frame with no TX byte and no strobes.
- States: IDLE, GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN, WR, RD_REQ, RD_WAIT, ALU_RUN, TX_SEND.
- IDLE, on RX_d_valid, latches the command and branches:
  - 8'hAA → GET_ADDR
  - 8'hBB → GET_ADDR
  - 8'hEE → GET_ADDR
  - 8'hCC → GET_A
  - 8'hDD → GET_FUN
  - any other value → err_pulse, then TX_send of ERR_BYTE.
- GET_ADDR latches RX_p_data[ADDR_WIDTH-1:0] into Address. Next state: AA → GET_DATA; BB → RD_REQ; EE → GET_CNT.
- GET_DATA latches WrData, then WR. WR pulses WrEN for 1 cycle, then IDLE. No TX response on write.
- GET_A latches WrData with Address=0 and pulses WrEN the following cycle. GET_B does the same with Address=1. Then GET_FUN.
- GET_FUN latches ALU_FUN=RX_p_data[FUN_WIDTH-1:0], then ALU_RUN.
- ALU_RUN holds ALU_EN=1 and CLK_EN=1 until OUT_VALID. It then captures ALU_OUT and queues RES_BYTES bytes, LSB first.
- RD_REQ pulses RdEN for 1 cycle. RD_WAIT accepts RdData_valid from the cycle after RdEN onward and queues Rd_data.
- Burst (EE): GET_CNT latches N.
  - N=0 → err_pulse, then ERR_BYTE sent.
  - Otherwise loops RD_REQ → RD_WAIT → TX_SEND N times. Address increments modulo 2^ADDR_WIDTH between reads (0xF wraps to 0x0). N > 2^ADDR_WIDTH is legal and rereads wrapped addresses.
- TX_SEND:
  - When FIFO_full=0: drives TX_p_data and pulses TX_d_valid for exactly 1 cycle per byte.
  - When FIFO_full=1: holds the byte with TX_d_valid=0. Bytes are never dropped.
  - After the last byte: IDLE, or the next burst read.
- Timeouts: a shared counter clears on every state change and on every accepted strobe.
  - In GET_* states, reaching TIMEOUT_CYCLES → timeout_pulse, IDLE, no TX.
  - In RD_WAIT or ALU_RUN → timeout_pulse, deassert ALU_EN/CLK_EN, send ERR_BYTE, abort any remaining burst.
- RX_d_valid in WR, RD_*, ALU_RUN or TX_SEND is ignored; the byte is dropped.
- RdData_valid or OUT_VALID outside its wait state is ignored.

Decomposition:
- Package sys_cntrl_pkg holds:
  - command constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD, CMD_BURST=8'hEE
  - the state enum
  - default ERR_BYTE
- One sub-module, frame_timer: a clearable counter with a saturating terminal-count pulse, parameter TIMEOUT_CYCLES.

Test Plan:
- AA,05,5A with FIFO_full=0 → one WrEN pulse with Address=5, WrData=0x5A; no TX_d_valid.
- BB,03, with Rd_data=0x77 returned two cycles after RdEN → one TX_d_valid with TX_p_data=0x77.
- CC,12,34,02 with ALU_OUT=0x03A8 → WrEN at Address 0 (0x12), then at Address 1 (0x34); ALU_FUN=2; TX bytes 0xA8 then 0x03.
- EE,0E,03 → reads at addresses 0xE, 0xF, 0x0; three TX bytes in order. FIFO_full held high 10 cycles during byte 2 → byte held, none lost.
- Command 0x42 → err_pulse, TX 0xFF. Then EE,00,00 → err_pulse, TX 0xFF.
- BB then no address byte for TIMEOUT_CYCLES → timeout_pulse, IDLE, no TX. RST asserted during ALU_RUN → ALU_EN=0 next edge, FSM returns to IDLE.
